// File: rtl/fic_apb_pkg.sv
// Shared definitions for the fabric-to-MSS APB arbiter: FSM encoding,
// default widths and timeout counter sizing.
package fic_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int TO_CNT_W_MIN       = 8;

  // Wait counter is at least 8 bits and grows if the timeout needs more.
  function automatic int to_cnt_w(input int cycles);
    return ($clog2(cycles + 1) > TO_CNT_W_MIN) ? $clog2(cycles + 1) : TO_CNT_W_MIN;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first eligible requester after last_gnt_i,
// wrapping around.
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [IDX_W-1:0]   last_gnt_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               any_valid_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && eligible_i[(int'(last_gnt_i) + k) % NUM_REQ]) begin
        found   = 1'b1;
        grant_o = IDX_W'((int'(last_gnt_i) + k) % NUM_REQ);
      end
    end
  end

  assign any_valid_o = |eligible_i;

endmodule

// File: rtl/fic_apb_arbiter.sv
// Round-robin sharing of the FIC_0 APB3 master port between NUM_REQ requesters.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module fic_apb_arbiter
  import fic_apb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       PCLK,
  input  logic                       PRESETN,
  input  logic [NUM_REQ-1:0]         REQ_VALID,
  input  logic [NUM_REQ-1:0]         REQ_WRITE,
  input  logic [NUM_REQ*ADDR_W-1:0]  REQ_ADDR,
  input  logic [NUM_REQ*DATA_W-1:0]  REQ_WDATA,
  output logic [NUM_REQ-1:0]         REQ_DONE,
  output logic [DATA_W-1:0]          RSP_RDATA,
  output logic                       RSP_ERR,
  output logic                       BUSY,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [ADDR_W-1:0]          PADDR,
  output logic [DATA_W-1:0]          PWDATA,
  input  logic [DATA_W-1:0]          PRDATA,
  input  logic                       PREADY,
  input  logic                       PSLVERR
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TO_W  = to_cnt_w(TIMEOUT_CYCLES);

  apb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   last_gnt_q, last_gnt_d, sel_idx;
  logic               sel_any;
  logic [NUM_REQ-1:0] eligible, done_q, done_d;
  logic               pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d, rdata_q, rdata_d;

`ifdef APB_TIMEOUT_EN
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
`else
  logic [TO_W-1:0]    unused_to_cnt;
  assign unused_to_cnt = TO_W'(TIMEOUT_CYCLES);
`endif

  // The requester being acknowledged this cycle must not win again immediately.
  assign eligible = REQ_VALID & ~done_q;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .eligible_i  (eligible),
    .last_gnt_i  (last_gnt_q),
    .grant_o     (sel_idx),
    .any_valid_o (sel_any)
  );

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    done_d     = '0;
    rdata_d    = rdata_q;
    err_d      = err_q;
`ifdef APB_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_any) begin
          last_gnt_d = sel_idx;
          pwrite_d   = REQ_WRITE[sel_idx];
          paddr_d    = REQ_ADDR[int'(sel_idx)*ADDR_W +: ADDR_W];
          pwdata_d   = REQ_WDATA[int'(sel_idx)*DATA_W +: DATA_W];
          psel_d     = 1'b1;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d             = 1'b0;
          penable_d          = 1'b0;
          done_d[last_gnt_q] = 1'b1;
          rdata_d            = pwrite_q ? '0 : PRDATA;
          err_d              = PSLVERR;
          state_d            = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          psel_d             = 1'b0;
          penable_d          = 1'b0;
          done_d[last_gnt_q] = 1'b1;
          rdata_d            = '0;
          err_d              = 1'b1;
          state_d            = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q    <= IDLE;
      last_gnt_q <= IDX_W'(NUM_REQ - 1);
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      done_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end
`endif

  assign REQ_DONE  = done_q;
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;
  assign BUSY      = (state_q != IDLE);
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_fic_apb_arbiter.sv
// Bench for fic_apb_arbiter: directed scenarios plus a randomized run checked
// against a round-robin transaction model.
module tb_fic_apb_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETN;
  logic [N-1:0]  REQ_VALID, REQ_WRITE, REQ_DONE;
  logic [N*AW-1:0] REQ_ADDR;
  logic [N*DW-1:0] REQ_WDATA;
  logic [DW-1:0] RSP_RDATA, PWDATA, PRDATA;
  logic [AW-1:0] PADDR;
  logic          RSP_ERR, BUSY, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  int total = 0;
  int bad   = 0;

  fic_apb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_DONE(REQ_DONE),
    .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    REQ_WRITE[i]          = w;
    REQ_ADDR[i*AW +: AW]  = a;
    REQ_WDATA[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    PRESETN = 1'b0; REQ_VALID = '0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    repeat (2) @(negedge PCLK);
    PRESETN = 1'b1;
    @(negedge PCLK);
  endtask

  task automatic wait_done(output logic [N-1:0] d, output int cyc, input int budget);
    d = '0; cyc = 0;
    while (cyc < budget) begin
      @(negedge PCLK);
      cyc++;
      if (REQ_DONE != '0) begin d = REQ_DONE; break; end
    end
  endtask

  task automatic test_reset();
    REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    do_reset();
    total++;
    if ({PSEL, PENABLE, PWRITE, BUSY, RSP_ERR} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {PSEL, PENABLE, PWRITE, BUSY, RSP_ERR});
    end
    total++;
    if ({REQ_DONE, RSP_RDATA, PADDR, PWDATA} !== '0) begin
      bad++; $display("FAIL reset_data: done=%b rdata=%h paddr=%h pwdata=%h", REQ_DONE, RSP_RDATA, PADDR, PWDATA);
    end
  endtask

  task automatic test_single_read();
    set_req(0, 1'b0, 32'h4000_1000, 32'h0);
    PRDATA = 32'hDEAD_BEEF; PREADY = 1'b1; REQ_VALID = 4'b0001;
    @(negedge PCLK);
    total++;
    if ({PSEL, PENABLE, PADDR} !== {2'b10, 32'h4000_1000}) begin
      bad++; $display("FAIL read_setup: psel=%b pen=%b paddr=%h want 1 0 40001000", PSEL, PENABLE, PADDR);
    end
    @(negedge PCLK);
    total++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b110) begin
      bad++; $display("FAIL read_access: got %b want 110", {PSEL, PENABLE, PWRITE});
    end
    @(negedge PCLK);
    total++;
    if ({REQ_DONE, RSP_RDATA, RSP_ERR, PSEL} !== {4'b0001, 32'hDEAD_BEEF, 2'b00}) begin
      bad++; $display("FAIL read_done: done=%b rdata=%h err=%b psel=%b", REQ_DONE, RSP_RDATA, RSP_ERR, PSEL);
    end
    REQ_VALID = '0;
    @(negedge PCLK);
    total++;
    if ({REQ_DONE, BUSY} !== 5'b0) begin
      bad++; $display("FAIL read_pulse: done=%b busy=%b want 0 0", REQ_DONE, BUSY);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] d;
    int cyc;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h4000_0000 + 32'(i * 16), 32'h0);
    PRDATA = 32'h5A5A_0001; PREADY = 1'b1; REQ_VALID = '1;
    for (int k = 0; k < 5; k++) begin
      wait_done(d, cyc, 12);
      total++;
      if (d !== 4'(1 << (k % N)) || cyc != 3) begin
        bad++; $display("FAIL rr_order[%0d]: done=%b after %0d cycles want %b after 3", k, d, cyc, 4'(1 << (k % N)));
      end
    end
    REQ_VALID = '0;
    repeat (2) @(negedge PCLK);
  endtask

  task automatic test_wait_write();
    int held = 0;
    set_req(2, 1'b1, 32'h4000_2004, 32'hCAFE_F00D);
    PRDATA = 32'h1234_5678; PREADY = 1'b0; REQ_VALID = 4'b0100;
    @(negedge PCLK);
    REQ_VALID = '0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge PCLK);
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, REQ_DONE} === {3'b111, 32'h4000_2004, 32'hCAFE_F00D, 4'b0}) held++;
      PREADY = (j == 6);
    end
    total++;
    if (held != 6) begin
      bad++; $display("FAIL wait_hold: access cycles stable=%0d want 6", held);
    end
    @(negedge PCLK);
    PREADY = 1'b0;
    total++;
    if ({REQ_DONE, RSP_RDATA, RSP_ERR} !== {4'b0100, 32'h0, 1'b0}) begin
      bad++; $display("FAIL wait_done: done=%b rdata=%h err=%b want 0100 0 0", REQ_DONE, RSP_RDATA, RSP_ERR);
    end
    @(negedge PCLK);
    total++;
    if (REQ_DONE !== 4'b0) begin
      bad++; $display("FAIL wait_once: done=%b want 0000", REQ_DONE);
    end
  endtask

  task automatic test_slverr();
    logic [N-1:0] d;
    int cyc;
    set_req(1, 1'b0, 32'h4000_3000, 32'h0);
    PRDATA = 32'h0BAD_0BAD; PREADY = 1'b1; PSLVERR = 1'b1; REQ_VALID = 4'b0010;
    wait_done(d, cyc, 12);
    REQ_VALID = '0; PSLVERR = 1'b0;
    total++;
    if ({d, RSP_ERR, RSP_RDATA} !== {4'b0010, 1'b1, 32'h0BAD_0BAD}) begin
      bad++; $display("FAIL slverr: done=%b err=%b rdata=%h want 0010 1 0bad0bad", d, RSP_ERR, RSP_RDATA);
    end
    set_req(3, 1'b0, 32'h4000_3004, 32'h0);
    PRDATA = 32'h0000_0077; REQ_VALID = 4'b1000;
    wait_done(d, cyc, 12);
    REQ_VALID = '0;
    total++;
    if ({d, RSP_ERR, RSP_RDATA} !== {4'b1000, 1'b0, 32'h77}) begin
      bad++; $display("FAIL slverr_next: done=%b err=%b rdata=%h want 1000 0 77", d, RSP_ERR, RSP_RDATA);
    end
  endtask

  task automatic test_masking();
    logic [N-1:0] d;
    int cyc;
    set_req(0, 1'b0, 32'h4000_4000, 32'h0);
    PREADY = 1'b1; REQ_VALID = 4'b0001;
    wait_done(d, cyc, 12);
    total++;
    if (d !== 4'b0001 || cyc != 3) begin
      bad++; $display("FAIL mask_first: done=%b after %0d want 0001 after 3", d, cyc);
    end
    wait_done(d, cyc, 12);
    REQ_VALID = '0;
    total++;
    if (d !== 4'b0001 || cyc != 4) begin
      bad++; $display("FAIL mask_regrant: done=%b after %0d want 0001 after 4", d, cyc);
    end
    repeat (2) @(negedge PCLK);
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] d;
    int cyc = 0;
    PREADY = 1'b0; REQ_VALID = '1;
    while (!(PSEL && PENABLE) && cyc < 10) begin @(negedge PCLK); cyc++; end
    PRESETN = 1'b0;
    #1;
    total++;
    if ({PSEL, PENABLE, BUSY, REQ_DONE} !== 7'b0 || cyc >= 10) begin
      bad++; $display("FAIL reset_mid: psel=%b pen=%b busy=%b done=%b want all 0", PSEL, PENABLE, BUSY, REQ_DONE);
    end
    @(negedge PCLK);
    PRESETN = 1'b1; PREADY = 1'b1;
    wait_done(d, cyc, 12);
    REQ_VALID = '0;
    total++;
    if (d !== 4'b0001 || cyc != 3) begin
      bad++; $display("FAIL reset_regrant: done=%b after %0d want 0001 after 3", d, cyc);
    end
    repeat (2) @(negedge PCLK);
  endtask

  task automatic test_timeout();
    logic [N-1:0] d;
    int cyc;
    set_req(0, 1'b0, 32'h4000_5000, 32'h0);
    PRDATA = 32'hFFFF_0000; PREADY = 1'b0; REQ_VALID = 4'b0001;
`ifdef APB_TIMEOUT_EN
    wait_done(d, cyc, 60);
    REQ_VALID = '0;
    total++;
    if ({d, RSP_ERR, RSP_RDATA} !== {4'b0001, 1'b1, 32'h0} || cyc != TO + 2) begin
      bad++; $display("FAIL timeout: done=%b err=%b rdata=%h after %0d want 0001 1 0 after %0d", d, RSP_ERR, RSP_RDATA, cyc, TO + 2);
    end
    @(negedge PCLK);
    total++;
    if ({BUSY, PSEL, PENABLE} !== 3'b0) begin
      bad++; $display("FAIL timeout_idle: got %b want 000", {BUSY, PSEL, PENABLE});
    end
`else
    wait_done(d, cyc, 1000);
    total++;
    if (d !== 4'b0 || {PSEL, PENABLE} !== 2'b11) begin
      bad++; $display("FAIL no_timeout: done=%b psel=%b pen=%b want 0000 1 1", d, PSEL, PENABLE);
    end
    do_reset();
`endif
  endtask

  task automatic test_random();
    logic [N-1:0] pend, prev_done, exp_done;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d, exp_rd;
    logic          exp_w, exp_err, prev_busy, rsp_pending;
    int model_last, exp_g, ndone, idx, guard;
    do_reset();
    model_last = N - 1; exp_g = 0; ndone = 0;
    prev_done = '0; prev_busy = 1'b0; rsp_pending = 1'b0;
    exp_a = '0; exp_d = '0; exp_w = 1'b0; exp_rd = '0; exp_err = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge PCLK);
      pend = REQ_VALID & ~prev_done;
      total++;
      if ((PSEL && !PENABLE) !== (!prev_busy && pend != '0)) begin
        bad++; $display("FAIL rnd_setup[%0d]: setup=%b pending=%b", c, PSEL && !PENABLE, pend);
      end
      if (PSEL && !PENABLE) begin
        exp_g = -1;
        for (int k = 1; k <= N && exp_g < 0; k++) begin
          idx = (model_last + k) % N;
          if (pend[idx]) exp_g = idx;
        end
        if (exp_g < 0) exp_g = 0;
        model_last = exp_g;
        exp_w = REQ_WRITE[exp_g]; exp_a = REQ_ADDR[exp_g*AW +: AW]; exp_d = REQ_WDATA[exp_g*DW +: DW];
      end
      if (PSEL) begin
        total++;
        if ({PWRITE, PADDR, PWDATA} !== {exp_w, exp_a, exp_d}) begin
          bad++; $display("FAIL rnd_apb[%0d]: got %b %h %h want %b %h %h req%0d", c, PWRITE, PADDR, PWDATA, exp_w, exp_a, exp_d, exp_g);
        end
      end
      exp_done = '0;
      if (rsp_pending) exp_done[exp_g] = 1'b1;
      total++;
      if (REQ_DONE !== exp_done || (PENABLE && !PSEL)) begin
        bad++; $display("FAIL rnd_done[%0d]: done=%b want %b pen=%b psel=%b", c, REQ_DONE, exp_done, PENABLE, PSEL);
      end
      if (rsp_pending) begin
        ndone++;
        total++;
        if ({RSP_RDATA, RSP_ERR} !== {exp_rd, exp_err}) begin
          bad++; $display("FAIL rnd_rsp[%0d]: rdata=%h err=%b want %h %b", c, RSP_RDATA, RSP_ERR, exp_rd, exp_err);
        end
        if ($urandom_range(0, 1) == 1) begin
          set_req(exp_g, 1'($urandom_range(0, 1)), $urandom, $urandom);
          REQ_VALID[exp_g] = 1'b1;
        end else begin
          REQ_VALID[exp_g] = 1'b0;
        end
      end
      prev_done = REQ_DONE; prev_busy = BUSY; rsp_pending = 1'b0;
      PRDATA = $urandom; PSLVERR = ($urandom_range(0, 7) == 0); PREADY = ($urandom_range(0, 2) != 0);
      if (PSEL && PENABLE && PREADY) begin
        rsp_pending = 1'b1; exp_rd = exp_w ? '0 : PRDATA; exp_err = PSLVERR;
      end
      if (PSEL && $urandom_range(0, 15) == 0) REQ_VALID[exp_g] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!REQ_VALID[i] && !REQ_DONE[i] && !(PSEL && i == exp_g) && $urandom_range(0, 3) == 0) begin
          set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
          REQ_VALID[i] = 1'b1;
        end
      end
    end
    REQ_VALID = '0; PREADY = 1'b1;
    guard = 0;
    while (BUSY && guard < 10) begin @(negedge PCLK); guard++; end
    total++;
    if (BUSY !== 1'b0 || ndone < 100) begin
      bad++; $display("FAIL rnd_progress: busy=%b completions=%0d want 0 and >=100", BUSY, ndone);
    end
  endtask

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: time=%0t limit=2000000", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESETN = 1'b0; REQ_VALID = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_write();
    test_slverr();
    test_masking();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
